// File: rtl/regpipe_issue_ctrl.sv
// Issue controller for the register/ALU/memory pipeline: queues instructions in a
// FIFO and issues one per cycle, holding the head while a source is still in flight.
module regpipe_issue_ctrl #(
    parameter int DEPTH  = 4,
    parameter int WB_LAT = 3
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_r1,
    input  logic [3:0]  in_r2,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_func,
    input  logic [7:0]  in_addr,
    input  logic        flush,
    output logic        iss_valid,
    output logic [3:0]  iss_r1,
    output logic [3:0]  iss_r2,
    output logic [3:0]  iss_rd,
    output logic [3:0]  iss_func,
    output logic [7:0]  iss_addr,
    output logic [15:0] issue_cnt,
    output logic [15:0] stall_cnt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SBN = WB_LAT - 1;

    typedef struct packed {
        logic [3:0] r1;
        logic [3:0] r2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } instr_t;

    instr_t      mem_q [DEPTH];
    instr_t      mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        sb_v_q  [SBN];
    logic        sb_v_d  [SBN];
    logic [3:0]  sb_rd_q [SBN];
    logic [3:0]  sb_rd_d [SBN];
    instr_t      iss_q, iss_d;
    logic        iss_valid_q, iss_valid_d;
    logic [15:0] issue_cnt_q, issue_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic   empty, full, hazard, do_issue, do_stall, do_push;
    instr_t head, in_instr;

    assign in_instr = {in_r1, in_r2, in_rd, in_func, in_addr};
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready = !full && !flush;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push  = in_valid && in_ready;
    assign do_issue = !empty && !hazard && !flush;
    assign do_stall = !empty && hazard && !flush;

    // Both sources are compared regardless of func; no forwarding path exists.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SBN; i++) begin
            if (sb_v_q[i] && ((sb_rd_q[i] == head.r1) || (sb_rd_q[i] == head.r2))) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        iss_d       = iss_q;
        iss_valid_d = do_issue;
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = in_instr;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_issue) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end

        if (do_issue) begin
            iss_d       = head;
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
        if (do_stall) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        // Scoreboard keeps shifting through flushes so retiring writes stay visible.
        sb_v_d[0]  = do_issue;
        sb_rd_d[0] = iss_d.rd;
        for (int i = 1; i < SBN; i++) begin
            sb_v_d[i]  = sb_v_q[i-1];
            sb_rd_d[i] = sb_rd_q[i-1];
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            for (int i = 0; i < SBN; i++) begin
                sb_v_q[i]  <= 1'b0;
                sb_rd_q[i] <= 4'd0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            iss_q       <= '0;
            iss_valid_q <= 1'b0;
            issue_cnt_q <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            for (int i = 0; i < SBN; i++) begin
                sb_v_q[i]  <= sb_v_d[i];
                sb_rd_q[i] <= sb_rd_d[i];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            iss_q       <= iss_d;
            iss_valid_q <= iss_valid_d;
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_r1    = iss_q.r1;
    assign iss_r2    = iss_q.r2;
    assign iss_rd    = iss_q.rd;
    assign iss_func  = iss_q.func;
    assign iss_addr  = iss_q.addr;
    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_regpipe_issue_ctrl.sv
// Directed bench for regpipe_issue_ctrl: a per-cycle vector table followed by
// hand-written backpressure, flush and reset-during-stall sequences.
module tb_regpipe_issue_ctrl;

    typedef struct packed {
        logic [3:0] r1;
        logic [3:0] r2;
        logic [3:0] rd;
        logic [3:0] fn;
        logic [7:0] a;
    } ins_t;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [3:0]  r1, r2, rd, fn;
        logic [7:0]  a;
        logic        fl;
        logic        chk_rdy;
        logic        e_rdy;
        logic        e_v;
        logic [3:0]  e_r1, e_r2, e_rd, e_fn;
        logic [7:0]  e_a;
        logic [15:0] e_ic, e_sc;
    } vec_t;

    logic        clk1 = 1'b0;
    logic        rst, in_valid, in_ready, flush, iss_valid;
    logic [3:0]  in_r1, in_r2, in_rd, in_func;
    logic [7:0]  in_addr;
    logic [3:0]  iss_r1, iss_r2, iss_rd, iss_func;
    logic [7:0]  iss_addr;
    logic [15:0] issue_cnt, stall_cnt;

    int total = 0;
    int bad   = 0;

    vec_t tbl [24];
    ins_t bp_list [7];
    ins_t got [$];

    always #5 clk1 = ~clk1;

    regpipe_issue_ctrl dut (
        .clk1      (clk1),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r1     (in_r1),
        .in_r2     (in_r2),
        .in_rd     (in_rd),
        .in_func   (in_func),
        .in_addr   (in_addr),
        .flush     (flush),
        .iss_valid (iss_valid),
        .iss_r1    (iss_r1),
        .iss_r2    (iss_r2),
        .iss_rd    (iss_rd),
        .iss_func  (iss_func),
        .iss_addr  (iss_addr),
        .issue_cnt (issue_cnt),
        .stall_cnt (stall_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst      = v.rst;
        in_valid = v.vld;
        in_r1    = v.r1;
        in_r2    = v.r2;
        in_rd    = v.rd;
        in_func  = v.fn;
        in_addr  = v.a;
        flush    = v.fl;
        #1;
    endtask

    task automatic drive(input logic v, input ins_t x, input logic fl);
        rst      = 1'b0;
        in_valid = v;
        in_r1    = x.r1;
        in_r2    = x.r2;
        in_rd    = x.rd;
        in_func  = x.fn;
        in_addr  = x.a;
        flush    = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    initial begin
        ins_t idle_ins;
        ins_t cur;
        int   k;
        bit   stop;
        idle_ins = '0;

        //          rst vld r1 r2 rd fn a    fl chk rdy v  er1 er2 erd efn ea  ic sc
        tbl[0]  = '{1, 1, 1, 2, 3, 4, 5,   0, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0};
        tbl[1]  = '{1, 1, 1, 2, 3, 4, 5,   0, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0};
        tbl[3]  = '{0, 1, 3, 5, 10, 0, 125, 0, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0};
        tbl[4]  = '{0, 1, 7, 5, 12, 1, 127, 0, 1, 1, 1, 3, 5, 10, 0, 125, 1, 0};
        tbl[5]  = '{0, 1, 8, 5, 11, 2, 128, 0, 1, 1, 1, 7, 5, 12, 1, 127, 2, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 8, 5, 11, 2, 128, 3, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 8, 5, 11, 2, 128, 3, 0};
        tbl[8]  = '{0, 1, 3, 5, 10, 0, 130, 0, 1, 1, 0, 8, 5, 11, 2, 128, 3, 0};
        tbl[9]  = '{0, 1, 10, 4, 13, 1, 131, 0, 1, 1, 1, 3, 5, 10, 0, 130, 4, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 3, 5, 10, 0, 130, 4, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 3, 5, 10, 0, 130, 4, 2};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 10, 4, 13, 1, 131, 5, 2};
        tbl[13] = '{0, 1, 3, 5, 10, 0, 140, 0, 1, 1, 0, 10, 4, 13, 1, 131, 5, 2};
        tbl[14] = '{0, 1, 4, 10, 14, 1, 141, 0, 1, 1, 1, 3, 5, 10, 0, 140, 6, 2};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 3, 5, 10, 0, 140, 6, 3};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 3, 5, 10, 0, 140, 6, 4};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 4, 10, 14, 1, 141, 7, 4};
        tbl[18] = '{0, 1, 1, 2, 10, 0, 150, 0, 1, 1, 0, 4, 10, 14, 1, 141, 7, 4};
        tbl[19] = '{0, 1, 6, 7, 8, 3, 151, 0, 1, 1, 1, 1, 2, 10, 0, 150, 8, 4};
        tbl[20] = '{0, 1, 10, 9, 15, 4, 152, 0, 1, 1, 1, 6, 7, 8, 3, 151, 9, 4};
        tbl[21] = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 6, 7, 8, 3, 151, 9, 5};
        tbl[22] = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 10, 9, 15, 4, 152, 10, 5};
        tbl[23] = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 10, 9, 15, 4, 152, 10, 5};

        for (int i = 0; i < 24; i++) begin
            applyStimulus(tbl[i]);
            if (tbl[i].chk_rdy) checkOutput($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            tick();
            checkOutput($sformatf("v%0d_iss_valid", i), 32'(iss_valid), 32'(tbl[i].e_v));
            checkOutput($sformatf("v%0d_iss_fields", i),
                        32'({iss_r1, iss_r2, iss_rd, iss_func, iss_addr}),
                        32'({tbl[i].e_r1, tbl[i].e_r2, tbl[i].e_rd, tbl[i].e_fn, tbl[i].e_a}));
            checkOutput($sformatf("v%0d_issue_cnt", i), 32'(issue_cnt), 32'(tbl[i].e_ic));
            checkOutput($sformatf("v%0d_stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].e_sc));
        end

        // Dependency chain keeps the head stalled long enough to fill the FIFO.
        bp_list[0] = '{4'd0, 4'd0, 4'd9, 4'd5,  8'd160};
        bp_list[1] = '{4'd9, 4'd0, 4'd1, 4'd6,  8'd161};
        bp_list[2] = '{4'd1, 4'd0, 4'd2, 4'd7,  8'd162};
        bp_list[3] = '{4'd2, 4'd0, 4'd3, 4'd8,  8'd163};
        bp_list[4] = '{4'd3, 4'd0, 4'd4, 4'd9,  8'd164};
        bp_list[5] = '{4'd4, 4'd0, 4'd5, 4'd10, 8'd165};
        bp_list[6] = '{4'd5, 4'd0, 4'd6, 4'd11, 8'd166};
        k = 0;
        stop = 1'b0;
        for (int cyc = 0; cyc < 20 && !stop && k < 7; cyc++) begin
            drive(1'b1, bp_list[k], 1'b0);
            #1;
            if (!in_ready) begin
                stop = 1'b1;
                checkOutput("bp_occupancy", 32'(k - got.size()), 32'd4);
            end else begin
                tick();
                k++;
                if (iss_valid) got.push_back({iss_r1, iss_r2, iss_rd, iss_func, iss_addr});
            end
        end
        checkOutput("bp_full_seen", 32'(stop), 32'd1);
        checkOutput("bp_accepted", 32'(k), 32'd6);
        drive(1'b0, idle_ins, 1'b0);
        for (int cyc = 0; cyc < 40 && got.size() < k; cyc++) begin
            tick();
            if (iss_valid) got.push_back({iss_r1, iss_r2, iss_rd, iss_func, iss_addr});
        end
        checkOutput("bp_issued", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            checkOutput($sformatf("bp_order%0d", i), 32'(got[i]), 32'(bp_list[i]));
        end
        checkOutput("bp_issue_cnt", 32'(issue_cnt), 32'd16);
        checkOutput("bp_stall_cnt", 32'(stall_cnt), 32'd15);
        for (int i = 0; i < 3; i++) tick();

        // Flush while the head waits on an in-flight rd=8.
        cur = '{4'd0, 4'd0, 4'd7, 4'd0, 8'd170};
        drive(1'b1, cur, 1'b0); tick();
        checkOutput("fl_e1_valid", 32'(iss_valid), 32'd0);
        cur = '{4'd7, 4'd0, 4'd8, 4'd1, 8'd171};
        drive(1'b1, cur, 1'b0); tick();
        checkOutput("fl_e2_rd", 32'({iss_valid, iss_rd}), 32'h17);
        cur = '{4'd8, 4'd0, 4'd1, 4'd2, 8'd172};
        drive(1'b1, cur, 1'b0); tick();
        checkOutput("fl_e3_stall", 32'(stall_cnt), 32'd16);
        cur = '{4'd9, 4'd9, 4'd2, 4'd3, 8'd173};
        drive(1'b1, cur, 1'b0); tick();
        checkOutput("fl_e4_stall", 32'(stall_cnt), 32'd17);
        cur = '{4'd9, 4'd9, 4'd3, 4'd4, 8'd174};
        drive(1'b1, cur, 1'b0); tick();
        checkOutput("fl_e5_rd", 32'({iss_valid, iss_rd}), 32'h18);
        checkOutput("fl_e5_issue_cnt", 32'(issue_cnt), 32'd18);
        cur = '{4'd0, 4'd0, 4'd0, 4'd5, 8'd175};
        drive(1'b1, cur, 1'b1);
        checkOutput("fl_in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("fl_e6_valid", 32'(iss_valid), 32'd0);
        checkOutput("fl_e6_stall", 32'(stall_cnt), 32'd17);
        cur = '{4'd8, 4'd0, 4'd9, 4'd6, 8'd176};
        drive(1'b1, cur, 1'b0);
        checkOutput("fl_ready_after", 32'(in_ready), 32'd1);
        tick();
        checkOutput("fl_e7_valid", 32'(iss_valid), 32'd0);
        drive(1'b0, idle_ins, 1'b0); tick();
        checkOutput("fl_e8_new", 32'({iss_valid, iss_rd, iss_addr}), 32'h19B0);
        checkOutput("fl_e8_issue_cnt", 32'(issue_cnt), 32'd19);
        tick();
        checkOutput("fl_e9_valid", 32'(iss_valid), 32'd0);
        checkOutput("fl_e9_issue_cnt", 32'(issue_cnt), 32'd19);

        // Reset arrives while a consumer is stalled; the stalled head must vanish.
        cur = '{4'd0, 4'd0, 4'd5, 4'd0, 8'd180};
        drive(1'b1, cur, 1'b0); tick();
        cur = '{4'd5, 4'd0, 4'd6, 4'd0, 8'd181};
        drive(1'b1, cur, 1'b0); tick();
        checkOutput("rs_prod_cnt", 32'(issue_cnt), 32'd20);
        drive(1'b0, idle_ins, 1'b0); tick();
        checkOutput("rs_stall_cnt", 32'(stall_cnt), 32'd18);
        rst = 1'b1;
        tick();
        checkOutput("rs_state", 32'({iss_valid, iss_rd, iss_addr}), 32'h0);
        checkOutput("rs_counters", {issue_cnt, stall_cnt}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("rs_idle%0d_valid", i), 32'(iss_valid), 32'd0);
            checkOutput($sformatf("rs_idle%0d_cnt", i), 32'(issue_cnt), 32'd0);
        end
        checkOutput("rs_in_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
